// File: rtl/seven_seg_scan_ctrl_if.sv
// Core-side bundle for the 6-digit 7-segment scan controller.
// The core (master) supplies the value, masks and control strobes; the
// controller (slave) returns the pin-level segment/select drive and status.
interface seven_seg_scan_ctrl_if;
   logic        i_ENABLE;
   logic        i_LOAD;
   logic [23:0] i_DIGITS;
   logic [5:0]  i_DP_MASK;
   logic [5:0]  i_BLANK_MASK;
   logic [6:0]  o_SEG;
   logic        o_SEG_DP;
   logic [5:0]  o_SEL;
   logic        o_PENDING;
   logic        o_FRAME_DONE;

   modport master (
      output i_ENABLE, i_LOAD, i_DIGITS, i_DP_MASK, i_BLANK_MASK,
      input  o_SEG, o_SEG_DP, o_SEL, o_PENDING, o_FRAME_DONE
   );

   modport slave (
      input  i_ENABLE, i_LOAD, i_DIGITS, i_DP_MASK, i_BLANK_MASK,
      output o_SEG, o_SEG_DP, o_SEL, o_PENDING, o_FRAME_DONE
   );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a 6-digit common-select 7-segment
// display. Each digit slot starts with a short all-dark gap to stop ghosting,
// then drives one select low with that digit's segments. Values from the core
// are double-buffered and only swapped in at the end of a full frame (or at
// once while the display is parked), so a frame never shows mixed values.
// The FSM registers describe the phase whose outputs are registered on the
// next edge, so outputs lag the phase registers by exactly one clock.
module seven_seg_scan_ctrl #(
   parameter logic [31:0] SCAN_DIVIDER = 32'hFF,
   parameter logic [31:0] BLANK_CYCLES = 32'd2
) (
   input logic                  i_SYS_CLOCK,
   input logic                  i_RESET_N,
   seven_seg_scan_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      BLANK = 2'd0,
      DRIVE = 2'd1,
      PARK  = 2'd2
   } state_t;

   localparam logic [31:0] DRIVE_CYCLES = SCAN_DIVIDER - BLANK_CYCLES;

   state_t      state_q, state_d, curState;
   logic [2:0]  idx_q, idx_d;
   logic [31:0] cnt_q, cnt_d;
   logic        boundary;
   logic        applyNow;

   logic [23:0] activeDigits_q, activeDigits_d;
   logic [5:0]  activeDp_q, activeDp_d;
   logic [5:0]  activeBlank_q, activeBlank_d;
   logic [23:0] pendDigits_q, pendDigits_d;
   logic [5:0]  pendDp_q, pendDp_d;
   logic [5:0]  pendBlank_q, pendBlank_d;
   logic        pending_q, pending_d;

   logic [5:0]  sel_q, sel_d;
   logic [6:0]  seg_q, seg_d;
   logic        segDp_q, segDp_d;
   logic        frameDone_q, frameDone_d;

   // Active-low hex to {G,F,E,D,C,B,A} segment pattern.
   function automatic logic [6:0] decodeHex(input logic [3:0] v);
      case (v)
         4'h0:    decodeHex = 7'h40;
         4'h1:    decodeHex = 7'h79;
         4'h2:    decodeHex = 7'h24;
         4'h3:    decodeHex = 7'h30;
         4'h4:    decodeHex = 7'h19;
         4'h5:    decodeHex = 7'h12;
         4'h6:    decodeHex = 7'h02;
         4'h7:    decodeHex = 7'h78;
         4'h8:    decodeHex = 7'h00;
         4'h9:    decodeHex = 7'h10;
         4'hA:    decodeHex = 7'h08;
         4'hB:    decodeHex = 7'h03;
         4'hC:    decodeHex = 7'h46;
         4'hD:    decodeHex = 7'h21;
         4'hE:    decodeHex = 7'h06;
         default: decodeHex = 7'h0E;
      endcase
   endfunction

   // Scan sequencing: advance the blank/drive phase, pick the digit drive for
   // the phase being left, and flag the last drive cycle of digit 5. A parked
   // display resumes as if it were at the first blank cycle of digit 0.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      sel_d       = 6'h3F;
      seg_d       = 7'h7F;
      segDp_d     = 1'b1;
      boundary    = 1'b0;
      curState    = (state_q == PARK) ? BLANK : state_q;
      if (!bus.i_ENABLE) begin
         state_d = PARK;
         idx_d   = 3'd0;
         cnt_d   = 32'd0;
      end else begin
         case (curState)
            BLANK: begin
               if (cnt_q == BLANK_CYCLES - 32'd1) begin
                  state_d = DRIVE;
                  cnt_d   = 32'd0;
               end else begin
                  state_d = BLANK;
                  cnt_d   = cnt_q + 32'd1;
               end
            end
            DRIVE: begin
               if (!activeBlank_q[idx_q]) begin
                  sel_d   = ~(6'b000001 << idx_q);
                  seg_d   = decodeHex(activeDigits_q[{idx_q, 2'b00} +: 4]);
                  segDp_d = ~activeDp_q[idx_q];
               end
               if (cnt_q == DRIVE_CYCLES - 32'd1) begin
                  state_d = BLANK;
                  cnt_d   = 32'd0;
                  if (idx_q == 3'd5) begin
                     idx_d    = 3'd0;
                     boundary = 1'b1;
                  end else begin
                     idx_d = idx_q + 3'd1;
                  end
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end
            default: begin
               state_d = BLANK;
               idx_d   = 3'd0;
               cnt_d   = 32'd0;
            end
         endcase
      end
      frameDone_d = boundary;
   end

   // Double buffer: loads always land in the pending copy; the pending copy
   // moves to the displayed copy at a frame boundary or whenever parked. A
   // load coinciding with the swap survives as the next pending value.
   always_comb begin
      activeDigits_d = activeDigits_q;
      activeDp_d     = activeDp_q;
      activeBlank_d  = activeBlank_q;
      pendDigits_d   = pendDigits_q;
      pendDp_d       = pendDp_q;
      pendBlank_d    = pendBlank_q;
      pending_d      = pending_q;
      applyNow       = boundary || (state_q == PARK);
      if (applyNow && pending_q) begin
         activeDigits_d = pendDigits_q;
         activeDp_d     = pendDp_q;
         activeBlank_d  = pendBlank_q;
      end
      if (bus.i_LOAD) begin
         pendDigits_d = bus.i_DIGITS;
         pendDp_d     = bus.i_DP_MASK;
         pendBlank_d  = bus.i_BLANK_MASK;
         pending_d    = 1'b1;
      end else if (applyNow) begin
         pending_d = 1'b0;
      end
   end

   // State, buffers and registered pin drive; reset leaves the display dark
   // and throws away anything waiting in the pending buffer.
   always_ff @(posedge i_SYS_CLOCK or negedge i_RESET_N) begin
      if (!i_RESET_N) begin
         state_q        <= BLANK;
         idx_q          <= 3'd0;
         cnt_q          <= 32'd0;
         activeDigits_q <= 24'd0;
         activeDp_q     <= 6'd0;
         activeBlank_q  <= 6'd0;
         pendDigits_q   <= 24'd0;
         pendDp_q       <= 6'd0;
         pendBlank_q    <= 6'd0;
         pending_q      <= 1'b0;
         sel_q          <= 6'h3F;
         seg_q          <= 7'h7F;
         segDp_q        <= 1'b1;
         frameDone_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         cnt_q          <= cnt_d;
         activeDigits_q <= activeDigits_d;
         activeDp_q     <= activeDp_d;
         activeBlank_q  <= activeBlank_d;
         pendDigits_q   <= pendDigits_d;
         pendDp_q       <= pendDp_d;
         pendBlank_q    <= pendBlank_d;
         pending_q      <= pending_d;
         sel_q          <= sel_d;
         seg_q          <= seg_d;
         segDp_q        <= segDp_d;
         frameDone_q    <= frameDone_d;
      end
   end

   assign bus.o_SEL        = sel_q;
   assign bus.o_SEG        = seg_q;
   assign bus.o_SEG_DP     = segDp_q;
   assign bus.o_PENDING    = pending_q;
   assign bus.o_FRAME_DONE = frameDone_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with an 8-cycle slot and 2 blank
// cycles. Frames are walked cycle by cycle; cycle c of a frame means the c-th
// rising edge of that frame, with outputs sampled 1 time unit after the edge.
module tb_seven_seg_scan_ctrl;

   logic clk = 1'b0;
   logic rstN = 1'b0;
   int   checks = 0;
   int   errors = 0;

   seven_seg_scan_ctrl_if bus();

   seven_seg_scan_ctrl #(
      .SCAN_DIVIDER(32'd8),
      .BLANK_CYCLES(32'd2)
   ) dut (
      .i_SYS_CLOCK(clk),
      .i_RESET_N  (rstN),
      .bus        (bus)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Select bus must never enable two digits at once.
   always @(negedge clk) begin
      if (rstN) begin
         checks++;
         if ($countones(~bus.o_SEL) > 1) begin
            errors++;
            $display("[TB] FAIL selOneHot sel=%h required at most one low bit", bus.o_SEL);
         end
      end
   end

   function automatic logic [6:0] segRef(input logic [3:0] v);
      case (v)
         4'h0: segRef = 7'h40; 4'h1: segRef = 7'h79; 4'h2: segRef = 7'h24; 4'h3: segRef = 7'h30;
         4'h4: segRef = 7'h19; 4'h5: segRef = 7'h12; 4'h6: segRef = 7'h02; 4'h7: segRef = 7'h78;
         4'h8: segRef = 7'h00; 4'h9: segRef = 7'h10; 4'hA: segRef = 7'h08; 4'hB: segRef = 7'h03;
         4'hC: segRef = 7'h46; 4'hD: segRef = 7'h21; 4'hE: segRef = 7'h06; default: segRef = 7'h0E;
      endcase
   endfunction

   // Expected {sel, seg, dp, frameDone} for frame cycle c (1..48).
   function automatic logic [14:0] expVec(input int c, input logic [23:0] dig,
                                          input logic [5:0] dpm, input logic [5:0] blm);
      int         slot;
      int         ph;
      logic [2:0] s3;
      logic [5:0] sel;
      logic [6:0] seg;
      logic       dp;
      slot = (c - 1) / 8;
      ph   = (c - 1) % 8;
      s3   = slot[2:0];
      sel  = 6'h3F;
      seg  = 7'h7F;
      dp   = 1'b1;
      if (ph >= 2 && blm[s3] == 1'b0) begin
         sel = ~(6'b000001 << s3);
         seg = segRef(dig[{s3, 2'b00} +: 4]);
         dp  = ~dpm[s3];
      end
      return {sel, seg, dp, (c == 48)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic driveLoad(input logic [23:0] d, input logic [5:0] dpm, input logic [5:0] blm);
      bus.i_DIGITS     = d;
      bus.i_DP_MASK    = dpm;
      bus.i_BLANK_MASK = blm;
      bus.i_LOAD       = 1'b1;
   endtask

   task automatic test_reset();
      bus.i_ENABLE = 1'b0;
      bus.i_LOAD   = 1'b0;
      bus.i_DIGITS = 24'd0;
      bus.i_DP_MASK = 6'd0;
      bus.i_BLANK_MASK = 6'd0;
      rstN = 1'b0;
      step();
      step();
      checks++; if (bus.o_SEL !== 6'h3F) begin errors++; $display("[TB] FAIL resetSel got=%h exp=3f", bus.o_SEL); end
      checks++; if (bus.o_SEG !== 7'h7F) begin errors++; $display("[TB] FAIL resetSeg got=%h exp=7f", bus.o_SEG); end
      checks++; if (bus.o_SEG_DP !== 1'b1) begin errors++; $display("[TB] FAIL resetDp got=%b exp=1", bus.o_SEG_DP); end
      checks++; if (bus.o_PENDING !== 1'b0) begin errors++; $display("[TB] FAIL resetPending got=%b exp=0", bus.o_PENDING); end
      checks++; if (bus.o_FRAME_DONE !== 1'b0) begin errors++; $display("[TB] FAIL resetFrameDone got=%b exp=0", bus.o_FRAME_DONE); end
   endtask

   // Frame 1 after release shows all zeros; the load at edge 1 waits.
   task automatic test_first_frame();
      logic [14:0] obs, exp;
      driveLoad(24'h543210, 6'd0, 6'd0);
      bus.i_ENABLE = 1'b1;
      rstN = 1'b1;
      for (int c = 1; c <= 48; c++) begin
         step();
         if (c == 1) begin
            bus.i_LOAD = 1'b0;
            checks++;
            if (bus.o_PENDING !== 1'b1) begin errors++; $display("[TB] FAIL firstPendingSet got=%b exp=1", bus.o_PENDING); end
         end
         obs = {bus.o_SEL, bus.o_SEG, bus.o_SEG_DP, bus.o_FRAME_DONE};
         exp = expVec(c, 24'h000000, 6'd0, 6'd0);
         checks++;
         if (obs !== exp) begin errors++; $display("[TB] FAIL frameZero c=%0d got=%h exp=%h", c, obs, exp); end
      end
      checks++;
      if (bus.o_PENDING !== 1'b0) begin errors++; $display("[TB] FAIL firstPendingClear got=%b exp=0", bus.o_PENDING); end
   endtask

   task automatic test_new_digits();
      logic [14:0] obs, exp;
      for (int c = 1; c <= 48; c++) begin
         step();
         obs = {bus.o_SEL, bus.o_SEG, bus.o_SEG_DP, bus.o_FRAME_DONE};
         exp = expVec(c, 24'h543210, 6'd0, 6'd0);
         checks++;
         if (obs !== exp) begin errors++; $display("[TB] FAIL frame543210 c=%0d got=%h exp=%h", c, obs, exp); end
      end
   endtask

   task automatic test_mid_frame_load();
      logic [14:0] obs, exp;
      for (int c = 1; c <= 48; c++) begin
         step();
         obs = {bus.o_SEL, bus.o_SEG, bus.o_SEG_DP, bus.o_FRAME_DONE};
         exp = expVec(c, 24'h543210, 6'd0, 6'd0);
         checks++;
         if (obs !== exp) begin errors++; $display("[TB] FAIL midLoadOld c=%0d got=%h exp=%h", c, obs, exp); end
         if (c == 19) driveLoad(24'hFEDCBA, 6'b000101, 6'b100000);
         if (c == 20) begin
            bus.i_LOAD = 1'b0;
            checks++;
            if (bus.o_PENDING !== 1'b1) begin errors++; $display("[TB] FAIL midLoadPending got=%b exp=1", bus.o_PENDING); end
         end
      end
      checks++;
      if (bus.o_PENDING !== 1'b0) begin errors++; $display("[TB] FAIL midLoadPendingClear got=%b exp=0", bus.o_PENDING); end
   endtask

   task automatic test_dp_blank();
      logic [14:0] obs, exp;
      for (int c = 1; c <= 48; c++) begin
         step();
         obs = {bus.o_SEL, bus.o_SEG, bus.o_SEG_DP, bus.o_FRAME_DONE};
         exp = expVec(c, 24'hFEDCBA, 6'b000101, 6'b100000);
         checks++;
         if (obs !== exp) begin errors++; $display("[TB] FAIL dpBlank c=%0d got=%h exp=%h", c, obs, exp); end
      end
   endtask

   // A second load sampled on the boundary edge is held for a whole frame.
   task automatic test_back_to_back();
      logic [14:0] obs, exp;
      for (int c = 1; c <= 48; c++) begin
         step();
         obs = {bus.o_SEL, bus.o_SEG, bus.o_SEG_DP, bus.o_FRAME_DONE};
         exp = expVec(c, 24'hFEDCBA, 6'b000101, 6'b100000);
         checks++;
         if (obs !== exp) begin errors++; $display("[TB] FAIL b2bFrameA c=%0d got=%h exp=%h", c, obs, exp); end
         if (c == 29) driveLoad(24'h111111, 6'd0, 6'd0);
         if (c == 30) bus.i_LOAD = 1'b0;
         if (c == 47) driveLoad(24'h222222, 6'd0, 6'd0);
      end
      bus.i_LOAD = 1'b0;
      checks++;
      if (bus.o_PENDING !== 1'b1) begin errors++; $display("[TB] FAIL b2bPendingKept got=%b exp=1", bus.o_PENDING); end
      for (int c = 1; c <= 48; c++) begin
         step();
         obs = {bus.o_SEL, bus.o_SEG, bus.o_SEG_DP, bus.o_FRAME_DONE};
         exp = expVec(c, 24'h111111, 6'd0, 6'd0);
         checks++;
         if (obs !== exp) begin errors++; $display("[TB] FAIL b2bFrameB c=%0d got=%h exp=%h", c, obs, exp); end
      end
      checks++;
      if (bus.o_PENDING !== 1'b0) begin errors++; $display("[TB] FAIL b2bPendingClear got=%b exp=0", bus.o_PENDING); end
      for (int c = 1; c <= 48; c++) begin
         step();
         obs = {bus.o_SEL, bus.o_SEG, bus.o_SEG_DP, bus.o_FRAME_DONE};
         exp = expVec(c, 24'h222222, 6'd0, 6'd0);
         checks++;
         if (obs !== exp) begin errors++; $display("[TB] FAIL b2bFrameC c=%0d got=%h exp=%h", c, obs, exp); end
      end
   endtask

   task automatic test_park();
      logic [14:0] obs, exp;
      for (int c = 1; c <= 30; c++) begin
         step();
         obs = {bus.o_SEL, bus.o_SEG, bus.o_SEG_DP, bus.o_FRAME_DONE};
         exp = expVec(c, 24'h222222, 6'd0, 6'd0);
         checks++;
         if (obs !== exp) begin errors++; $display("[TB] FAIL parkPre c=%0d got=%h exp=%h", c, obs, exp); end
      end
      bus.i_ENABLE = 1'b0;
      step();
      obs = {bus.o_SEL, bus.o_SEG, bus.o_SEG_DP, bus.o_FRAME_DONE};
      checks++;
      if (obs !== {6'h3F, 7'h7F, 1'b1, 1'b0}) begin errors++; $display("[TB] FAIL parkDark got=%h exp=%h", obs, {6'h3F, 7'h7F, 1'b1, 1'b0}); end
      driveLoad(24'h333333, 6'd0, 6'd0);
      step();
      bus.i_LOAD = 1'b0;
      checks++;
      if (bus.o_PENDING !== 1'b1) begin errors++; $display("[TB] FAIL parkPendingSet got=%b exp=1", bus.o_PENDING); end
      step();
      checks++;
      if (bus.o_PENDING !== 1'b0) begin errors++; $display("[TB] FAIL parkPendingApplied got=%b exp=0", bus.o_PENDING); end
      for (int i = 0; i < 20; i++) begin
         step();
         obs = {bus.o_SEL, bus.o_SEG, bus.o_SEG_DP, bus.o_FRAME_DONE};
         checks++;
         if (obs !== {6'h3F, 7'h7F, 1'b1, 1'b0}) begin errors++; $display("[TB] FAIL parkHold i=%0d got=%h exp=%h", i, obs, {6'h3F, 7'h7F, 1'b1, 1'b0}); end
      end
      bus.i_ENABLE = 1'b1;
      for (int c = 1; c <= 48; c++) begin
         step();
         obs = {bus.o_SEL, bus.o_SEG, bus.o_SEG_DP, bus.o_FRAME_DONE};
         exp = expVec(c, 24'h333333, 6'd0, 6'd0);
         checks++;
         if (obs !== exp) begin errors++; $display("[TB] FAIL parkResume c=%0d got=%h exp=%h", c, obs, exp); end
      end
   endtask

   task automatic test_reset_midframe();
      logic [14:0] obs, exp;
      for (int c = 1; c <= 21; c++) begin
         step();
         obs = {bus.o_SEL, bus.o_SEG, bus.o_SEG_DP, bus.o_FRAME_DONE};
         exp = expVec(c, 24'h333333, 6'd0, 6'd0);
         checks++;
         if (obs !== exp) begin errors++; $display("[TB] FAIL rstPre c=%0d got=%h exp=%h", c, obs, exp); end
         if (c == 20) driveLoad(24'hABCDEF, 6'h3F, 6'd0);
         if (c == 21) begin
            bus.i_LOAD = 1'b0;
            checks++;
            if (bus.o_PENDING !== 1'b1) begin errors++; $display("[TB] FAIL rstPendingSet got=%b exp=1", bus.o_PENDING); end
         end
      end
      #2;
      rstN = 1'b0;
      #1;
      obs = {bus.o_SEL, bus.o_SEG, bus.o_SEG_DP, bus.o_FRAME_DONE};
      checks++;
      if (obs !== {6'h3F, 7'h7F, 1'b1, 1'b0}) begin errors++; $display("[TB] FAIL rstAsyncOut got=%h exp=%h", obs, {6'h3F, 7'h7F, 1'b1, 1'b0}); end
      checks++;
      if (bus.o_PENDING !== 1'b0) begin errors++; $display("[TB] FAIL rstAsyncPending got=%b exp=0", bus.o_PENDING); end
      step();
      step();
      rstN = 1'b1;
      for (int c = 1; c <= 48; c++) begin
         step();
         obs = {bus.o_SEL, bus.o_SEG, bus.o_SEG_DP, bus.o_FRAME_DONE};
         exp = expVec(c, 24'h000000, 6'd0, 6'd0);
         checks++;
         if (obs !== exp) begin errors++; $display("[TB] FAIL rstPostFrame c=%0d got=%h exp=%h", c, obs, exp); end
      end
      checks++;
      if (bus.o_PENDING !== 1'b0) begin errors++; $display("[TB] FAIL rstPostPending got=%b exp=0", bus.o_PENDING); end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_new_digits();
      test_mid_frame_load();
      test_dp_blank();
      test_back_to_back();
      test_park();
      test_reset_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
